// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the fetch_queue instruction front-end.
package fetch_queue_pkg;

    localparam int          FQ_XLEN     = 32;
    localparam logic [31:0] FQ_RESET_PC = 32'h0;
    localparam int          FQ_PC_INC   = 4;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fq_state_t;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with a combinational head and a synchronous flush.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  CW      = $clog2(DEPTH) + 1,
    parameter type entry_t = fq_entry_t
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential PC generation, one outstanding fetch, prefetch buffer to decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = FQ_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FQ_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    fq_state_t       state;
    fq_state_t       state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [XLEN-1:0] pending_pc;
    logic [XLEN-1:0] pending_pc_next;
    logic [XLEN-1:0] target;
    logic            fire;
    logic            push;
    logic            pop;
    entry_t          wdata;
    entry_t          head;
    logic [CW-1:0]   unused_count;
    logic            fifo_empty;
    logic            fifo_full;

    assign target    = redirect_pc & ~XLEN'(3);
    assign fire      = imem_req && imem_ack;
    assign imem_addr = fetch_pc;
    assign wdata     = '{pc: fetch_pc, inst: imem_rdata};

    // The redirect cycle hides the head so decode never consumes a stale instruction.
    assign inst_valid = !fifo_empty && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? head.inst : '0;
    assign inst_pc    = inst_valid ? head.pc   : '0;

    fetch_queue_fifo #(
        .DEPTH   (DEPTH),
        .CW      (CW),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wdata),
        .rdata (head),
        .count (unused_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            pending_pc <= pending_pc_next;
        end
    end

    // imem_req is gated by rst so it drops immediately on reset assertion, before any clock edge.
    always_comb begin
        state_next      = state;
        fetch_pc_next   = fetch_pc;
        pending_pc_next = pending_pc;
        push            = 1'b0;
        imem_req        = 1'b0;
        case (state)
            RUN: begin
                imem_req = rst && !fifo_full;
                if (redirect) begin
                    if (fire || !imem_req) begin
                        fetch_pc_next = target;
                    end else begin
                        pending_pc_next = target;
                        state_next      = DROP;
                    end
                end else if (fire) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc + XLEN'(FQ_PC_INC);
                end
            end
            DROP: begin
                // The abandoned fetch must still complete; its address stays on the bus until ack.
                imem_req = rst;
                if (fire) begin
                    state_next    = RUN;
                    fetch_pc_next = redirect ? target : pending_pc;
                end else if (redirect) begin
                    pending_pc_next = target;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run against a queue model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          XLEN  = 32;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_drop;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    task automatic idle_inputs();
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %0b want 0", imem_req); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b want 0", inst_valid); end
        total++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_head: got inst=%h pc=%h want 0/0", inst, inst_pc); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ K;
            #1;
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                bad++; $display("[TB] FAIL stream_fetch[%0d]: got req=%0b addr=%h want 1/%h", k, imem_req, imem_addr, 32'(4 * k));
            end
            if (k > 0) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (k - 1)) || inst !== (32'(4 * (k - 1)) ^ K)) begin
                    bad++; $display("[TB] FAIL stream_out[%0d]: got v=%0b pc=%h inst=%h want 1/%h/%h",
                                    k, inst_valid, inst_pc, inst, 32'(4 * (k - 1)), 32'(4 * (k - 1)) ^ K);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fill();
        do_reset();
        inst_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ K;
            #1;
            total++; if (imem_addr !== 32'(4 * k)) begin bad++; $display("[TB] FAIL fill_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * k)); end
            @(negedge clk);
        end
        inst_ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            imem_ack   = imem_req;
            imem_rdata = imem_addr ^ K;
            #1;
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * j) || inst !== (32'(4 * j) ^ K)) begin
                bad++; $display("[TB] FAIL fill_pop[%0d]: got v=%0b pc=%h inst=%h want pc=%h", j, inst_valid, inst_pc, inst, 32'(4 * j));
            end
            if (j < 2) begin
                total++;
                if (imem_req !== (j == 1) || imem_addr !== 32'h10) begin
                    bad++; $display("[TB] FAIL fill_req[%0d]: got req=%0b addr=%h want %0b/10", j, imem_req, imem_addr, (j == 1));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        inst_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int w = 0; w < 4; w++) begin
                imem_ack   = (w == 3);
                imem_rdata = imem_addr ^ K;
                #1;
                if (w == 3) begin
                    total++; if (imem_addr !== 32'(4 * f)) begin bad++; $display("[TB] FAIL lat_addr[%0d]: got %h want %h", f, imem_addr, 32'(4 * f)); end
                end
                @(negedge clk);
            end
        end
        imem_ack = 1'b0;
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL drop_w2: got req=%0b addr=%h want 1/8", imem_req, imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop_valid: got %0b want 0", inst_valid); end
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL drop_w3: got req=%0b addr=%h want 1/8", imem_req, imem_addr); end
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL drop_ack_addr: got %h want 8", imem_addr); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("[TB] FAIL drop_newaddr: got req=%0b addr=%h want 1/40", imem_req, imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop_discard: got v=%0b pc=%h want 0", inst_valid, inst_pc); end
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'h40 ^ K;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== (32'h40 ^ K)) begin bad++; $display("[TB] FAIL drop_first: got v=%0b pc=%h inst=%h want 1/40", inst_valid, inst_pc, inst); end
        @(negedge clk);
    endtask

    task automatic test_redirect_ack_wrap();
        do_reset();
        inst_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ K;
            @(negedge clk);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        imem_rdata  = 32'h1234_5678;
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL ackredir_valid: got %0b want 0", inst_valid); end
        @(negedge clk);
        redirect_pc = 32'h43;
        #1;
        total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin bad++; $display("[TB] FAIL ackredir_next: got v=%0b req=%0b addr=%h want 0/1/80", inst_valid, imem_req, imem_addr); end
        @(negedge clk);
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        total++; if (imem_addr !== 32'h40) begin bad++; $display("[TB] FAIL misalign: got %h want 40", imem_addr); end
        @(negedge clk);
        redirect   = 1'b0;
        inst_ready = 1'b1;
        imem_rdata = imem_addr ^ K;
        #1;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_top: got %h want fffffffc", imem_addr); end
        @(negedge clk);
        imem_rdata = imem_addr ^ K;
        #1;
        total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL wrap_zero: got %h want 0", imem_addr); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_out: got v=%0b pc=%h want 1/fffffffc", inst_valid, inst_pc); end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        total++; if (inst_pc !== 32'h0 || inst !== K) begin bad++; $display("[TB] FAIL wrap_out0: got pc=%h inst=%h want 0/%h", inst_pc, inst, K); end
        @(negedge clk);
    endtask

    task automatic test_reset_midwait();
        do_reset();
        inst_ready = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = K;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || inst_valid !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("[TB] FAIL midwait_pre: got req=%0b v=%0b addr=%h want 1/1/4", imem_req, inst_valid, imem_addr); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL midwait_async: got req=%0b v=%0b want 0/0", imem_req, inst_valid); end
        total++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin bad++; $display("[TB] FAIL midwait_head: got inst=%h pc=%h want 0/0", inst, inst_pc); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL midwait_restart: got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int          mem_wait;
        bit          exp_req;
        bit          exp_valid;
        bit          fire;
        logic [31:0] tgt;
        ent_t        e;
        do_reset();
        mq.delete();
        m_pc     = 32'h0;
        m_pend   = 32'h0;
        m_drop   = 1'b0;
        mem_wait = -1;
        for (int c = 0; c < 3000; c++) begin
            inst_ready  = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom();
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            imem_rdata  = $urandom();
            exp_req     = m_drop || (mq.size() < DEPTH);
            imem_ack    = 1'b0;
            if (exp_req) begin
                if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
                imem_ack = (mem_wait == 0);
                if (imem_ack) mem_wait = -1; else mem_wait--;
            end
            exp_valid = (mq.size() > 0) && !redirect;
            #1;
            total++; if (imem_req !== exp_req) begin bad++; $display("[TB] FAIL rnd_req[%0d]: got %0b want %0b", c, imem_req, exp_req); end
            if (exp_req) begin
                total++; if (imem_addr !== m_pc) begin bad++; $display("[TB] FAIL rnd_addr[%0d]: got %h want %h", c, imem_addr, m_pc); end
            end
            total++; if (inst_valid !== exp_valid) begin bad++; $display("[TB] FAIL rnd_valid[%0d]: got %0b want %0b", c, inst_valid, exp_valid); end
            if (exp_valid) begin
                total++;
                if (inst_pc !== mq[0].pc || inst !== mq[0].inst) begin
                    bad++; $display("[TB] FAIL rnd_head[%0d]: got pc=%h inst=%h want %h/%h", c, inst_pc, inst, mq[0].pc, mq[0].inst);
                end
            end
            fire = exp_req && imem_ack;
            if (redirect) begin
                mq.delete();
                tgt = {redirect_pc[31:2], 2'b00};
                if (fire) begin
                    m_pc   = tgt;
                    m_drop = 1'b0;
                end else if (exp_req) begin
                    m_pend = tgt;
                    m_drop = 1'b1;
                end else begin
                    m_pc = tgt;
                end
            end else begin
                if (exp_valid && inst_ready) void'(mq.pop_front());
                if (fire) begin
                    if (m_drop) begin
                        m_pc   = m_pend;
                        m_drop = 1'b0;
                    end else begin
                        e.pc   = m_pc;
                        e.inst = imem_rdata;
                        mq.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream();
        test_fill();
        test_redirect_drop();
        test_redirect_ack_wrap();
        test_reset_midwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
